// File: rtl/seq_detector_param_if.sv
// Serial pattern detector bus: configuration, serial input and match status.
// Master drives config and data; slave is the detector.
interface seq_detector_param_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
  logic               load;
  logic [MAX_LEN-1:0] pat_in;
  logic [LEN_W-1:0]   len_in;
  logic               overlap_en;
  logic               mealy_mode;
  logic               x;
  logic               x_valid;
  logic               detect_out;
  logic [CNT_W-1:0]   match_count;
  logic               count_sat;

  modport master (
    output load, pat_in, len_in,
    output overlap_en, mealy_mode,
    output x, x_valid,
    input  detect_out, match_count,
    input  count_sat
  );

  modport slave (
    input  load, pat_in, len_in,
    input  overlap_en, mealy_mode,
    input  x, x_valid,
    output detect_out, match_count,
    output count_sat
  );
endinterface

// File: rtl/seq_detector_param.sv
// Run-time programmable serial bit-pattern detector with Mealy/Moore output,
// overlap control, input qualifier and saturating match counter.
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic clk,
  input  logic reset,
  seq_detector_param_if.slave bus
);

  logic [MAX_LEN-1:0] pat_q;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovl_q;
  logic               mealy_q;
  logic               moore_q;

  logic [MAX_LEN-1:0] win;
  logic [MAX_LEN-1:0] mask;
  logic               accept;
  logic               full;
  logic               hit;

  always_comb begin
    len_d = bus.len_in;
    if (bus.len_in == '0)
      len_d = LEN_W'(1);
    else if (bus.len_in > LEN_W'(MAX_LEN))
      len_d = LEN_W'(MAX_LEN);
  end

  // Window of the last MAX_LEN bits including the bit arriving now
  assign win = {hist_q[MAX_LEN-2:0], bus.x};

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++)
      mask[i] = (LEN_W'(i) < len_q);
  end

  assign accept = bus.x_valid & ~bus.load;
  assign full   = ({1'b0, fill_q} + (LEN_W + 1)'(1))
                  >= {1'b0, len_q};
  assign hit    = accept & full
                  & (((win ^ pat_q) & mask) == '0);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    if (bus.load) begin
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (accept) begin
      hist_d = win;
      if (hit && !ovl_q)
        fill_d = '0;
      else if (fill_q != LEN_W'(MAX_LEN))
        fill_d = fill_q + LEN_W'(1);
      if (hit && !(&cnt_q))
        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q   <= '0;
      len_q   <= LEN_W'(1);
      ovl_q   <= 1'b1;
      mealy_q <= 1'b1;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      moore_q <= 1'b0;
    end else begin
      if (bus.load) begin
        pat_q   <= bus.pat_in;
        len_q   <= len_d;
        ovl_q   <= bus.overlap_en;
        mealy_q <= bus.mealy_mode;
      end
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      moore_q <= hit;
    end
  end

  // Output is forced low during reset and on the load cycle
  assign bus.detect_out  = ~reset & ~bus.load
                           & (mealy_q ? hit : moore_q);
  assign bus.match_count = cnt_q;
  assign bus.count_sat   = &cnt_q;

endmodule
